moore_seq_det_param: RTL and testbench



---
 rtl/moore_seq_det_param.sv | 66 ++++++
 tb/tb_moore_seq_det_param.sv | 135 +++++++++++++
 2 files changed

// File: rtl/moore_seq_det_param.sv
// moore_seq_det_param: parametrised Moore serial pattern detector with KMP fallback and saturating match counter
module moore_seq_det_param #(
    parameter int N = 6,
    parameter logic [N-1:0] PATTERN = 6'b110110,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W = 8,
    localparam int SW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state
);
    typedef enum logic [SW-1:0] {S_IDLE = '0, S_DETECT = SW'(N)} state_t;

    // Longest pattern prefix that is a suffix of (first h pattern bits, then b); PATTERN[N-1] is bit 0 of the sequence
    function automatic logic [SW-1:0] fallback(input int k, input logic b);
        int h;
        logic ok;
        logic [SW-1:0] best;
        h = (k == N && !OVERLAP) ? 0 : k;
        best = '0;
        for (int j = 1; j <= N; j++) begin
            if (j <= h + 1) begin
                ok = (b == PATTERN[N-j]);
                for (int i = 0; i < j - 1; i++)
                    ok = ok && (PATTERN[N-1-(h+1-j+i)] == PATTERN[N-1-i]);
                if (ok) best = SW'(j);
            end
        end
        return best;
    endfunction

    logic [SW-1:0] tbl [2*N+2];
    for (genvar k = 0; k <= N; k++) begin : g_tbl
        assign tbl[2*k]   = fallback(k, 1'b0);
        assign tbl[2*k+1] = fallback(k, 1'b1);
    end

    state_t st;
    state_t nxt;
    assign nxt   = (st > S_DETECT) ? S_IDLE : state_t'(tbl[{st, x}]);
    assign state = st;

    // Illegal encodings fall back to idle on the next edge even without en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            z         <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (en || st > S_DETECT) begin
                st <= nxt;
                z  <= (nxt == S_DETECT);
            end
            if (clr_cnt)
                match_cnt <= '0;
            else if (en && nxt == S_DETECT && match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_moore_seq_det_param.sv
// tb_moore_seq_det_param: three detector configurations under shared stimulus, checked against a history-based model
module tb_moore_seq_det_param;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, x = 1'b0, clr_cnt = 1'b0;
    always #5 clk = ~clk;

    logic z0, z1, z2;
    logic [2:0] s0, s1, s2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    moore_seq_det_param u0 (.clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
                            .z(z0), .match_cnt(c0), .state(s0));
    moore_seq_det_param #(.N(6), .PATTERN(6'b110110), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .z(z1), .match_cnt(c1), .state(s1));
    moore_seq_det_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
        .z(z2), .match_cnt(c2), .state(s2));

    localparam int NN [3] = '{6, 6, 4};
    localparam logic [15:0] PAT [3] = '{16'b110110, 16'b110110, 16'b1111};
    localparam bit OV [3] = '{1'b1, 1'b0, 1'b1};
    localparam int CW [3] = '{8, 8, 2};

    int total = 0, bad = 0;
    int qs [3][$];
    logic [31:0] hist [3];
    int hlen [3], mst [3], mcnt [3];
    int act [3];

    function automatic int enc(input int s, input int zz, input int c);
        return (s << 20) | (zz << 16) | c;
    endfunction

    always_comb begin
        act[0] = enc(int'(s0), int'(z0), int'(c0));
        act[1] = enc(int'(s1), int'(z1), int'(c1));
        act[2] = enc(int'(s2), int'(z2), int'(c2));
    end

    // Longest pattern prefix equal to a suffix of the accepted-bit history (newest bit in h[0])
    function automatic int longest(input logic [31:0] h, input int hl, input int n, input logic [15:0] p);
        int best;
        bit ok;
        best = 0;
        for (int j = 1; j <= n; j++) begin
            if (j <= hl) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++)
                    if (h[j-1-i] != p[n-1-i]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got state=%0d z=%0d cnt=%0d, want state=%0d z=%0d cnt=%0d", name,
                     got >> 20, (got >> 16) & 1, got & 'hffff, exp >> 20, (exp >> 16) & 1, exp & 'hffff);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            if (qs[i].size() > 0) check($sformatf("inst%0d", i), act[i], qs[i].pop_front());
    end

    task automatic step(input logic r, input logic e, input logic b, input logic c);
        @(negedge clk);
        rst = r; en = e; x = b; clr_cnt = c;
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                hist[i] = '0; hlen[i] = 0; mst[i] = 0; mcnt[i] = 0;
            end else begin
                if (e) begin
                    if (mst[i] == NN[i] && !OV[i]) hlen[i] = 0;
                    hist[i] = {hist[i][30:0], b};
                    if (hlen[i] < 32) hlen[i]++;
                    mst[i] = longest(hist[i], hlen[i], NN[i], PAT[i]);
                end
                if (c) mcnt[i] = 0;
                else if (e && mst[i] == NN[i] && mcnt[i] < (1 << CW[i]) - 1) mcnt[i]++;
            end
            qs[i].push_back(enc(mst[i], int'(mst[i] == NN[i]), mcnt[i]));
        end
        if (!r) begin
            #1;
            for (int i = 0; i < 3; i++) check($sformatf("async_rst%0d", i), act[i], 0);
        end
    endtask

    task automatic send(input logic [15:0] v, input int len);
        for (int k = len - 1; k >= 0; k--) step(1'b1, 1'b1, v[k], 1'b0);
    endtask

    initial begin
        int pend;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b110110110, 9);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b110110110110, 12);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b11011, 5);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, k[0], 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b1101, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        send(16'b110110, 6);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b11011, 5);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send(16'b110100, 6);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
        repeat (3) @(negedge clk);
        pend = qs[0].size() + qs[1].size() + qs[2].size();
        total++;
        if (pend != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", pend);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
